// File: rtl/cpu_core_pkg.sv
// Shared definitions for the cpu_core slice: opcodes, FSM encoding,
// flag bit positions, instruction layout and the default reset vector.
package cpu_core_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_8000;

   // FSM encoding
   localparam logic [1:0] ST_FETCH   = 2'd0;
   localparam logic [1:0] ST_DECODE  = 2'd1;
   localparam logic [1:0] ST_EXECUTE = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;

   // Opcodes
   localparam logic [5:0] OP_ADD   = 6'h00;
   localparam logic [5:0] OP_SUB   = 6'h01;
   localparam logic [5:0] OP_AND   = 6'h02;
   localparam logic [5:0] OP_OR    = 6'h03;
   localparam logic [5:0] OP_XOR   = 6'h04;
   localparam logic [5:0] OP_NOT   = 6'h05;
   localparam logic [5:0] OP_SHL   = 6'h06;
   localparam logic [5:0] OP_SHR   = 6'h07;
   localparam logic [5:0] OP_MUL   = 6'h08;
   localparam logic [5:0] OP_DIV   = 6'h09;
   localparam logic [5:0] OP_MOD   = 6'h0A;
   localparam logic [5:0] OP_CMP   = 6'h0B;
   localparam logic [5:0] OP_SAR   = 6'h0C;
   localparam logic [5:0] OP_LOADI = 6'h22;
   localparam logic [5:0] OP_HALT  = 6'h50 & 6'h3F;

   // Bit positions inside the 4-bit flag register {V, N, Z, C}
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   // Instruction word layout; imm[13:0] overlaps {rs2, low9}
   typedef struct packed {
      logic [5:0] opcode;
      logic [1:0] rsvd;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [8:0] low9;
   } instr_t;

   function automatic logic [31:0] sext14(input logic [13:0] v);
      return {{18{v[13]}}, v};
   endfunction

endpackage

// File: rtl/cpu_core_reg_file.sv
// 32 x 32-bit register file: R0 hard-wired to zero, two combinational
// read ports, one synchronous write port, cleared by reset.
module reg_file (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o
);

   logic [31:0] registers [0:31];

   // Synchronous write; writes aimed at R0 are dropped
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) registers[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         registers[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0 : registers[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0 : registers[raddr2_i];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle core: FETCH -> DECODE -> EXECUTE, combinational ALU,
// HALT state held until reset. Memory writes and I/O are not used.
//
// Fetch handshake: mem_read is the request (valid) and stays high with a
// stable addr_bus while in FETCH; mem_ready is the response (ready). The
// instruction is taken from data_bus on the rising edge where both are 1.
module cpu_core
   import cpu_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] addr_bus,
   inout  wire  [31:0] data_bus,
   output logic        mem_read,
   output logic        mem_write,
   input  logic        mem_ready,
   input  logic [7:0]  interrupt_req,
   output logic        interrupt_ack,
   output logic [7:0]  io_addr,
   inout  wire  [7:0]  io_data,
   output logic        io_read,
   output logic        io_write,
   output logic        halted,
   output logic        user_mode,
   output logic [7:0]  cpu_flags,
   output logic [1:0]  fsm_state_o
);

   logic [1:0]  state_q;
   logic [31:0] pc_q;
   instr_t      ir_q;
   logic [3:0]  flags_q, flags_d;
   logic        halted_q;
   logic [31:0] op_a_q, op_b_q, imm_q;
   logic [31:0] rdata1, rdata2;

   logic [31:0] alu_res;
   logic        alu_c, alu_v, alu_wr, alu_fe;
   logic [32:0] sum, diff, shl_t, shr_t;
   logic signed [32:0] sar_t;
   logic [31:0] prod;
   logic [4:0]  sh;
   logic        unused_ok;

   assign data_bus      = 'z;
   assign io_data       = 'z;
   assign mem_write     = 1'b0;
   assign interrupt_ack = 1'b0;
   assign io_addr       = 8'h00;
   assign io_read       = 1'b0;
   assign io_write      = 1'b0;
   assign user_mode     = 1'b0;
   assign unused_ok     = ^{interrupt_req, ir_q.rsvd};

   assign addr_bus    = pc_q;
   assign mem_read    = (state_q == ST_FETCH);
   assign halted      = halted_q;
   assign cpu_flags   = {4'b0000, flags_q};
   assign fsm_state_o = state_q;

   reg_file reg_file_inst (
      .clk_i    (clk),
      .rst_i    (rst),
      .we_i     ((state_q == ST_EXECUTE) && alu_wr),
      .waddr_i  (ir_q.rd),
      .wdata_i  (alu_res),
      .raddr1_i (ir_q.rs1),
      .raddr2_i (ir_q.rs2),
      .rdata1_o (rdata1),
      .rdata2_o (rdata2)
   );

   // Shared datapath terms; shifters carry one extra bit to catch the last bit out
   assign sh    = op_b_q[4:0];
   assign sum   = {1'b0, op_a_q} + {1'b0, op_b_q};
   assign diff  = {1'b0, op_a_q} - {1'b0, op_b_q};
   assign shl_t = {1'b0, op_a_q} << sh;
   assign shr_t = {op_a_q, 1'b0} >> sh;
   assign sar_t = $signed({op_a_q, 1'b0}) >>> sh;
   assign prod  = op_a_q * op_b_q;

   // ALU: result, write enable and flag update for the instruction in IR
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_wr  = 1'b0;
      alu_fe  = 1'b0;
      case (ir_q.opcode)
         OP_ADD: begin
            alu_res = sum[31:0]; alu_c = sum[32]; alu_wr = 1'b1; alu_fe = 1'b1;
            alu_v = (op_a_q[31] == op_b_q[31]) && (alu_res[31] != op_a_q[31]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = diff[31:0]; alu_c = diff[32]; alu_fe = 1'b1;
            alu_wr  = (ir_q.opcode == OP_SUB);
            alu_v = (op_a_q[31] != op_b_q[31]) && (alu_res[31] != op_a_q[31]);
         end
         OP_AND: begin alu_res = op_a_q & op_b_q; alu_wr = 1'b1; alu_fe = 1'b1; end
         OP_OR:  begin alu_res = op_a_q | op_b_q; alu_wr = 1'b1; alu_fe = 1'b1; end
         OP_XOR: begin alu_res = op_a_q ^ op_b_q; alu_wr = 1'b1; alu_fe = 1'b1; end
         OP_NOT: begin alu_res = ~op_a_q;         alu_wr = 1'b1; alu_fe = 1'b1; end
         OP_SHL: begin
            alu_res = shl_t[31:0]; alu_c = shl_t[32]; alu_wr = 1'b1; alu_fe = 1'b1;
         end
         OP_SHR: begin
            alu_res = shr_t[32:1]; alu_c = shr_t[0]; alu_wr = 1'b1; alu_fe = 1'b1;
         end
         OP_SAR: begin
            alu_res = sar_t[32:1]; alu_c = sar_t[0]; alu_wr = 1'b1; alu_fe = 1'b1;
         end
         OP_MUL: begin alu_res = prod; alu_wr = 1'b1; alu_fe = 1'b1; end
         OP_DIV: begin
            alu_res = (op_b_q == 32'h0) ? 32'hFFFF_FFFF : op_a_q / op_b_q;
            alu_wr = 1'b1; alu_fe = 1'b1;
         end
         OP_MOD: begin
            alu_res = (op_b_q == 32'h0) ? op_a_q : op_a_q % op_b_q;
            alu_wr = 1'b1; alu_fe = 1'b1;
         end
         OP_LOADI: begin alu_res = op_a_q + imm_q; alu_wr = 1'b1; end
         default: ;
      endcase
      flags_d = flags_q;
      if (alu_fe) begin
         flags_d[FLAG_C] = alu_c;
         flags_d[FLAG_Z] = (alu_res == 32'h0);
         flags_d[FLAG_N] = alu_res[31];
         flags_d[FLAG_V] = alu_v;
      end
   end

   // Control FSM, PC, IR, operand latches and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         flags_q  <= '0;
         halted_q <= 1'b0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         imm_q    <= '0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (mem_ready) begin
                  ir_q    <= instr_t'(data_bus);
                  state_q <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               op_a_q  <= rdata1;
               op_b_q  <= rdata2;
               imm_q   <= sext14({ir_q.rs2, ir_q.low9});
               state_q <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               if (ir_q.opcode == OP_HALT) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else begin
                  flags_q <= flags_d;
                  pc_q    <= pc_q + 32'd4;
                  state_q <= ST_FETCH;
               end
            end
            default: state_q <= ST_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: table of ALU vectors plus random vectors run as tiny
// programs from a bench-side instruction memory, and hand sequences for the
// reference program, fetch stalls, divide by R0 and reset while halted.
module tb_cpu_core;

   localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, AND_ = 6'h02, OR_ = 6'h03,
                          XOR_ = 6'h04, NOT_ = 6'h05, SHL = 6'h06, SHR = 6'h07,
                          MUL = 6'h08, DIV = 6'h09, MOD = 6'h0A, CMP = 6'h0B,
                          SAR = 6'h0C, LOADI = 6'h22, NOP = 6'h3F;
   localparam logic [31:0] HALT_W = 32'h5000_0000 << 2;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_ready = 1'b1;
   logic [7:0]  interrupt_req = 8'h00;
   logic [31:0] addr_bus;
   wire  [31:0] data_bus;
   wire  [7:0]  io_data;
   logic        mem_read, mem_write, interrupt_ack, io_read, io_write;
   logic        halted, user_mode;
   logic [7:0]  io_addr, cpu_flags;
   logic [1:0]  fsm_state_o;

   always #5 clk = ~clk;

   cpu_core dut (
      .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
      .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
      .interrupt_req(interrupt_req), .interrupt_ack(interrupt_ack),
      .io_addr(io_addr), .io_data(io_data), .io_read(io_read),
      .io_write(io_write), .halted(halted), .user_mode(user_mode),
      .cpu_flags(cpu_flags), .fsm_state_o(fsm_state_o)
   );

   // Instruction memory at 0x8000
   logic [31:0] imem [0:63];
   logic [31:0] bus_word;
   always_comb begin
      bus_word = 32'h0;
      if (addr_bus[31:8] == 24'h000080) bus_word = imem[addr_bus[7:2]];
   end
   assign data_bus = bus_word;

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   int pc_idx = 0;
   logic [39:0] exp_q[$];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- program builder ----------------
   function automatic logic [31:0] enc_rr(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, 2'b00, rd, rs1, rs2, 9'h000};
   endfunction

   function automatic logic [31:0] enc_ri(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [13:0] imm);
      return {op, 2'b00, rd, rs1, imm};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) imem[i] = HALT_W;
      pc_idx = 0;
   endtask

   task automatic emit(input logic [31:0] w);
      imem[pc_idx] = w;
      pc_idx++;
   endtask

   // Builds any 32-bit constant in r; relies on R31 holding 10, uses R30
   task automatic load_const(input logic [4:0] r, input logic [31:0] v);
      emit(enc_ri(LOADI, r, 5'd0, {2'b00, v[31:20]}));
      emit(enc_rr(SHL, r, r, 5'd31));
      emit(enc_ri(LOADI, 5'd30, 5'd0, {4'h0, v[19:10]}));
      emit(enc_rr(OR_, r, r, 5'd30));
      emit(enc_rr(SHL, r, r, 5'd31));
      emit(enc_ri(LOADI, 5'd30, 5'd0, {4'h0, v[9:0]}));
      emit(enc_rr(OR_, r, r, 5'd30));
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_to_halt(input int budget, output int cycles);
      cycles = 0;
      while (!halted && cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      if (!halted) begin
         tests++;
         fails++;
         $display("FAIL halt_timeout: got no halt after %0d cycles", cycles);
      end
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [39:0] model(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      logic c, v, z, n;
      int s;
      s = int'(b[4:0]);
      r = 32'h0; c = 1'b0; v = 1'b0;
      case (op)
         ADD: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[31] ~^ b[31]) & (r[31] ^ a[31]); end
         SUB, CMP: begin r = a - b; c = (a < b); v = (a[31] ^ b[31]) & (r[31] ^ a[31]); end
         AND_: r = a & b;
         OR_:  r = a | b;
         XOR_: r = a ^ b;
         NOT_: r = ~a;
         SHL: begin r = a << s; c = (s == 0) ? 1'b0 : a[32 - s]; end
         SHR: begin r = a >> s; c = (s == 0) ? 1'b0 : a[s - 1]; end
         SAR: begin r = $signed(a) >>> s; c = (s == 0) ? 1'b0 : a[s - 1]; end
         MUL: r = a * b;
         DIV: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         MOD: r = (b == 0) ? a : a % b;
         default: r = 32'h0;
      endcase
      z = (r == 32'h0);
      n = r[31];
      if (op == CMP) r = 32'h0;
      return {4'h0, v, n, z, c, r};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_r;
      logic [7:0]  exp_f;
   } vec_t;

   vec_t vecs[23];
   logic [5:0] alu_ops[13];

   task automatic run_vector(input string name, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [39:0] exp);
      logic [39:0] e;
      int cyc;
      clear_mem();
      emit(enc_ri(LOADI, 5'd31, 5'd0, 14'd10));
      load_const(5'd1, a);
      load_const(5'd2, b);
      emit(enc_rr(op, 5'd3, 5'd1, 5'd2));
      emit(HALT_W);
      exp_q.push_back(exp);
      apply_reset();
      rst = 1'b0;
      run_to_halt(300, cyc);
      e = exp_q.pop_front();
      check32({name, "_res"}, dut.reg_file_inst.registers[3], e[31:0]);
      check32({name, "_flags"}, {24'h0, cpu_flags}, {24'h0, e[39:32]});
      check32({name, "_halted"}, {31'h0, halted}, 32'h1);
   endtask

   initial begin
      int cyc;
      logic [31:0] ra, rb;
      logic [5:0] rop;

      vecs[0]  = '{ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 8'h0C};
      vecs[1]  = '{ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         8'h03};
      vecs[2]  = '{SUB,  32'd5,         32'd3,         32'd2,         8'h00};
      vecs[3]  = '{SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 8'h05};
      vecs[4]  = '{SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 8'h08};
      vecs[5]  = '{CMP,  32'd5,         32'd3,         32'h0,         8'h00};
      vecs[6]  = '{CMP,  32'd9,         32'd9,         32'h0,         8'h02};
      vecs[7]  = '{AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 8'h04};
      vecs[8]  = '{OR_,  32'h0,         32'h0,         32'h0,         8'h02};
      vecs[9]  = '{XOR_, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 8'h04};
      vecs[10] = '{NOT_, 32'h0,         32'd3,         32'hFFFF_FFFF, 8'h04};
      vecs[11] = '{SHL,  32'h8000_0001, 32'd1,         32'h2,         8'h01};
      vecs[12] = '{SHR,  32'h3,         32'd1,         32'h1,         8'h01};
      vecs[13] = '{SAR,  32'h8000_0000, 32'd4,         32'hF800_0000, 8'h04};
      vecs[14] = '{SAR,  32'h8000_000F, 32'd4,         32'hF800_0000, 8'h05};
      vecs[15] = '{SHL,  32'h1,         32'h25,        32'h20,        8'h00};
      vecs[16] = '{SHR,  32'h1234_5678, 32'h0,         32'h1234_5678, 8'h00};
      vecs[17] = '{MUL,  32'h0001_0000, 32'h0001_0000, 32'h0,         8'h02};
      vecs[18] = '{MUL,  32'd7,         32'd6,         32'd42,        8'h00};
      vecs[19] = '{DIV,  32'd100,       32'd7,         32'd14,        8'h00};
      vecs[20] = '{MOD,  32'd100,       32'd7,         32'd2,         8'h00};
      vecs[21] = '{DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 8'h04};
      vecs[22] = '{MOD,  32'd7,         32'd0,         32'd7,         8'h00};
      alu_ops = '{ADD, SUB, AND_, OR_, XOR_, NOT_, SHL, SHR, SAR, MUL, DIV, MOD, CMP};

      // Reset state
      clear_mem();
      apply_reset();
      check32("rst_addr", addr_bus, 32'h0000_8000);
      check32("rst_ctrl", {26'h0, mem_read, mem_write, halted, interrupt_ack, io_read, io_write},
              32'h20);
      check32("rst_tied", {15'h0, user_mode, io_addr, cpu_flags}, 32'h0);
      check32("rst_state", {30'h0, fsm_state_o}, 32'h0);

      // Table vectors
      foreach (vecs[i])
         run_vector($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    {vecs[i].exp_f, vecs[i].exp_r});

      // Random vectors against the model
      for (int i = 0; i < 12; i++) begin
         rop = alu_ops[$urandom_range(0, 12)];
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         run_vector($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb, model(rop, ra, rb));
      end

      // Reference program
      clear_mem();
      emit(enc_ri(LOADI, 5'd1, 5'd0, 14'd5));
      emit(enc_ri(LOADI, 5'd2, 5'd0, 14'd3));
      emit(enc_rr(ADD, 5'd3, 5'd1, 5'd2));
      emit(enc_rr(SUB, 5'd4, 5'd1, 5'd2));
      emit(enc_rr(AND_, 5'd5, 5'd1, 5'd2));
      emit(enc_rr(OR_, 5'd6, 5'd1, 5'd2));
      emit(enc_rr(XOR_, 5'd7, 5'd1, 5'd2));
      emit(enc_rr(NOT_, 5'd8, 5'd1, 5'd0));
      emit(enc_rr(SHL, 5'd9, 5'd1, 5'd2));
      emit(enc_rr(SHR, 5'd10, 5'd1, 5'd2));
      emit(enc_rr(SAR, 5'd11, 5'd1, 5'd2));
      emit(enc_rr(MUL, 5'd12, 5'd1, 5'd2));
      emit(enc_rr(DIV, 5'd13, 5'd1, 5'd2));
      emit(enc_rr(MOD, 5'd14, 5'd1, 5'd2));
      emit(enc_rr(CMP, 5'd15, 5'd1, 5'd2));
      emit(HALT_W);
      apply_reset();
      rst = 1'b0;
      run_to_halt(200, cyc);
      check32("prog_cycles", cyc, 32'd48);
      check32("prog_r3", dut.reg_file_inst.registers[3], 32'd8);
      check32("prog_r4", dut.reg_file_inst.registers[4], 32'd2);
      check32("prog_r5", dut.reg_file_inst.registers[5], 32'd1);
      check32("prog_r6", dut.reg_file_inst.registers[6], 32'd7);
      check32("prog_r7", dut.reg_file_inst.registers[7], 32'd6);
      check32("prog_r8", dut.reg_file_inst.registers[8], ~32'd5);
      check32("prog_r9", dut.reg_file_inst.registers[9], 32'd40);
      check32("prog_r10", dut.reg_file_inst.registers[10], 32'd0);
      check32("prog_r11", dut.reg_file_inst.registers[11], 32'd0);
      check32("prog_r12", dut.reg_file_inst.registers[12], 32'd15);
      check32("prog_r13", dut.reg_file_inst.registers[13], 32'd1);
      check32("prog_r14", dut.reg_file_inst.registers[14], 32'd2);
      check32("prog_r15", dut.reg_file_inst.registers[15], 32'd0);
      check32("prog_flags", {24'h0, cpu_flags}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check32("halt_hold", {addr_bus[30:0], mem_read}, {32'h0000_803C} << 1);
      end

      // Reset while halted
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check32("rsthalt_halted", {31'h0, halted}, 32'h0);
      check32("rsthalt_addr", addr_bus, 32'h0000_8000);
      check32("rsthalt_read", {31'h0, mem_read}, 32'h1);
      check32("rsthalt_r3", dut.reg_file_inst.registers[3], 32'h0);

      // Fetch stall, R0 write discard, NOP, LOADI flag behaviour
      clear_mem();
      emit(enc_ri(LOADI, 5'd1, 5'd0, 14'd5));
      emit(enc_ri(LOADI, 5'd0, 5'd0, 14'd9));
      emit(enc_rr(ADD, 5'd3, 5'd1, 5'd0));
      emit(enc_rr(NOP, 5'd7, 5'd1, 5'd1));
      emit(enc_ri(LOADI, 5'd4, 5'd1, 14'h3FFA));
      emit(enc_rr(ADD, 5'd5, 5'd0, 5'd0));
      emit(enc_ri(LOADI, 5'd6, 5'd0, 14'h3FFF));
      emit(HALT_W);
      mem_ready = 1'b0;
      apply_reset();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check32($sformatf("stall%0d", i), {addr_bus[31:3], mem_read, fsm_state_o},
                 {29'h0000_1000, 3'b100});
      end
      mem_ready = 1'b1;
      run_to_halt(200, cyc);
      check32("stall_cycles", cyc, 32'd24);
      check32("stall_r3", dut.reg_file_inst.registers[3], 32'd5);
      check32("stall_r4", dut.reg_file_inst.registers[4], 32'hFFFF_FFFF);
      check32("stall_r5", dut.reg_file_inst.registers[5], 32'd0);
      check32("stall_r6", dut.reg_file_inst.registers[6], 32'hFFFF_FFFF);
      check32("stall_r7", dut.reg_file_inst.registers[7], 32'd0);
      check32("stall_flags", {24'h0, cpu_flags}, 32'h02);
      check32("stall_haltpc", addr_bus, 32'h0000_801C);

      // Divide and modulo by R0
      clear_mem();
      emit(enc_ri(LOADI, 5'd1, 5'd0, 14'd7));
      emit(enc_rr(DIV, 5'd3, 5'd1, 5'd0));
      emit(enc_rr(MOD, 5'd4, 5'd1, 5'd0));
      emit(HALT_W);
      apply_reset();
      rst = 1'b0;
      run_to_halt(100, cyc);
      check32("divr0_q", dut.reg_file_inst.registers[3], 32'hFFFF_FFFF);
      check32("modr0_r", dut.reg_file_inst.registers[4], 32'd7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
